// File: rtl/queen_board_checker.sv
// Collects N one-hot rows, checks N-queen legality, reports first error.
// Keeps saturating counts of boards checked and boards rejected.
module queen_board_checker #(
  parameter int N     = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             row_valid,
  input  logic [N-1:0]     row_data,
  output logic             busy,
  output logic             result_valid,
  output logic             board_ok,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] board_count,
  output logic [CNT_W-1:0] fail_count
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam int DN = 2 * N - 1;
  localparam int DW = (DN > 1) ? $clog2(DN) : 1;

  localparam logic [2:0] E_NONE = 3'd0;
  localparam logic [2:0] E_HOT  = 3'd1;
  localparam logic [2:0] E_COL  = 3'd2;
  localparam logic [2:0] E_DIAG = 3'd3;
  localparam logic [2:0] E_ANTI = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_REPORT
  } state_t;

  state_t          r_state;
  logic [IW-1:0]   r_row_idx;
  logic [N-1:0]    r_col_mask;
  logic [DN-1:0]   r_diag_mask;
  logic [DN-1:0]   r_anti_mask;
  logic [2:0]      r_err;

  logic            w_accept;
  logic            w_last;
  logic            w_onehot;
  logic [IW-1:0]   w_col;
  logic [DW-1:0]   w_diag_idx;
  logic [DW-1:0]   w_anti_idx;
  logic [2:0]      w_code;
  logic [2:0]      w_final_err;

  assign w_accept = row_valid && (r_state != S_REPORT);
  assign w_last   = (r_row_idx == IW'(N - 1));
  assign w_onehot = $onehot(row_data);

  always_comb begin
    w_col = '0;
    for (int c = 0; c < N; c++) begin
      if (row_data[c]) begin
        w_col = IW'(c);
      end
    end
  end

  // r + N-1 is formed before subtracting c so the index never wraps
  assign w_diag_idx = DW'(r_row_idx) + DW'(N - 1) - DW'(w_col);
  assign w_anti_idx = DW'(r_row_idx) + DW'(w_col);

  always_comb begin
    w_code = E_NONE;
    if (!w_onehot) begin
      w_code = E_HOT;
    end else if (r_col_mask[w_col]) begin
      w_code = E_COL;
    end else if (r_diag_mask[w_diag_idx]) begin
      w_code = E_DIAG;
    end else if (r_anti_mask[w_anti_idx]) begin
      w_code = E_ANTI;
    end
  end

  assign w_final_err = (r_err != E_NONE) ? r_err : w_code;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_row_idx    <= '0;
      r_col_mask   <= '0;
      r_diag_mask  <= '0;
      r_anti_mask  <= '0;
      r_err        <= E_NONE;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      board_ok     <= 1'b0;
      err_code     <= E_NONE;
      board_count  <= '0;
      fail_count   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE, S_COLLECT: begin
          if (w_accept) begin
            if (r_err == E_NONE) begin
              r_err <= w_code;
            end
            if (w_onehot) begin
              r_col_mask              <= r_col_mask | row_data;
              r_diag_mask[w_diag_idx] <= 1'b1;
              r_anti_mask[w_anti_idx] <= 1'b1;
            end
            busy <= 1'b1;
            if (w_last) begin
              // outputs land together so they are valid in the REPORT cycle
              r_state      <= S_REPORT;
              result_valid <= 1'b1;
              board_ok     <= (w_final_err == E_NONE);
              err_code     <= w_final_err;
              if (board_count != '1) begin
                board_count <= board_count + CNT_W'(1);
              end
              if ((w_final_err != E_NONE) && (fail_count != '1)) begin
                fail_count <= fail_count + CNT_W'(1);
              end
            end else begin
              r_state   <= S_COLLECT;
              r_row_idx <= r_row_idx + IW'(1);
            end
          end
        end
        S_REPORT: begin
          r_state      <= S_IDLE;
          r_row_idx    <= '0;
          r_col_mask   <= '0;
          r_diag_mask  <= '0;
          r_anti_mask  <= '0;
          r_err        <= E_NONE;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/queen_board_checker.md
Name: queen_board_checker

Overview:
- Downstream consumer of the eight_queen solver's board output.
- Accepts one N-bit row per handshake; row r carries a one-hot column position.
- After N rows it reports whether the board is a legal N-queen placement, with the first error found, and keeps running board and failure counts.
- Sits between the solver's out_bus and the result/display logic.

Parameters:
N, 8, board size (rows, columns, bits per row)
CNT_W, 8, width of board_count and fail_count

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
row_valid  input  1  row_data valid this cycle
row_data  input  N  one row; bit c set = queen in column c
busy  output  1  board collection or report in progress
result_valid  output  1  one-cycle pulse: board_ok/err_code updated
board_ok  output  1  last checked board legal
err_code  output  3  first error of last board
board_count  output  CNT_W  boards checked, saturating
fail_count  output  CNT_W  illegal boards, saturating

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous and active-high.
- Reset values: all outputs 0. Internal state is IDLE, row_idx=0, all masks cleared.
- IDLE, busy=0:
  - row_valid=1 accepts the row as row 0 and moves to COLLECT with row_idx=1.
- COLLECT, busy=1:
  - Each row_valid=1 cycle accepts row row_idx and increments row_idx.
  - Gaps with row_valid=0 are allowed. There is no timeout.
- Per-row checks for accepted row r with column c, in priority order:
  - 1: row_data not one-hot (zero or multiple bits set).
  - 2: col_mask[c] already set.
  - 3: diagonal mask bit (r-c+N-1) already set; 2N-1 bits wide.
  - 4: anti-diagonal mask bit (r+c) already set; 2N-1 bits wide.
  - Code 0 means no error.
- Error latching:
  - Only the first error, in row order, is latched for the board.
  - Masks are updated only for one-hot rows.
  - Remaining rows are still consumed after an error.
- Completion: the cycle that accepts row N-1 moves the FSM to REPORT.
- REPORT, busy=1, lasts exactly one cycle:
  - result_valid=1.
  - board_ok = (latched err==0); err_code = latched error.
  - board_count increments, saturating at 2^CNT_W-1.
  - fail_count increments if illegal, also saturating.
  - Masks and row_idx clear; the next state is IDLE.
  - row_valid during REPORT is ignored.
- Latency: result_valid is high in the cycle immediately after the edge that sampled the last row.
- board_ok and err_code hold their values until the next REPORT.
- Reset mid-collection discards the partial board and clears the counters. No result_valid is produced for the discarded board.

Test Plan:
- Legal board, back-to-back rows 0x01,0x10,0x80,0x20,0x04,0x40,0x02,0x08 -> result_valid pulses one cycle after the 8th row; board_ok=1, err_code=0, board_count=1, fail_count=0.
- Same board with row 3 = 0x00 -> board_ok=0, err_code=1, fail_count=1. Repeat with row 3 = 0x24 -> err_code=1.
- Rows 0x01,0x01 then six legal-width rows -> err_code=2. A later diagonal clash in the same board does not overwrite code 2.
- Rows 0x01,0x02,... -> err_code=3. Rows 0x02,0x01,... -> err_code=4.
- Legal board with random 0–5 cycle row_valid gaps, plus row_valid held high during REPORT -> identical result to back-to-back; the REPORT-cycle row is dropped.
- Reset after 4 rows, then a full legal board -> no pulse before reset; after the full board result_valid=1, board_ok=1, board_count=1.
- With CNT_W=2, submit 5 illegal boards -> board_count and fail_count saturate at 3.
